// File: rtl/button_router.sv
// Push-button front end: synchronise, debounce and polarity-correct N keys plus the mode switch,
// then route pressed levels and one-cycle press strobes to the command or value channel.
module button_router #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int CNT_W           = 19
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              SW,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] CMD_Reg,
  output logic [N_KEYS-1:0] KEY_Reg,
  output logic [N_KEYS-1:0] CMD_Pulse,
  output logic [N_KEYS-1:0] KEY_Pulse,
  output logic              MODE
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_KEYS-1:0] key_p;
  logic [N_KEYS-1:0] key_s1_q, key_s2_q;
  logic [N_KEYS-1:0] key_stable_q, key_stable_d;
  logic [N_KEYS-1:0] key_prev_q;
  logic [CNT_W-1:0]  key_cnt_q [N_KEYS];
  logic [CNT_W-1:0]  key_cnt_d [N_KEYS];

  logic              sw_s1_q, sw_s2_q;
  logic              sw_stable_q, sw_stable_d;
  logic [CNT_W-1:0]  sw_cnt_q, sw_cnt_d;

  logic              mode_q, mode_d;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] cmd_reg_q, key_reg_q, cmd_pulse_q, key_pulse_q;

  // Internal polarity: 1 = pressed, so cleared sync flops read as released.
  assign key_p = KEY ^ {N_KEYS{KEY_ACTIVE_LOW}};

  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      key_stable_d[i] = key_stable_q[i];
      key_cnt_d[i]    = '0;
      if (key_s2_q[i] != key_stable_q[i]) begin
        if (key_cnt_q[i] == CNT_MAX) begin
          key_stable_d[i] = key_s2_q[i];
        end else begin
          key_cnt_d[i] = key_cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    sw_stable_d = sw_stable_q;
    sw_cnt_d    = '0;
    if (sw_s2_q != sw_stable_q) begin
      if (sw_cnt_q == CNT_MAX) begin
        sw_stable_d = sw_s2_q;
      end else begin
        sw_cnt_d = sw_cnt_q + CNT_ONE;
      end
    end
  end

  // A pending mode change waits until every key reads released, so no press changes channel.
  assign mode_d = (key_stable_q == '0) ? sw_stable_q : mode_q;
  assign rise   = key_stable_q & ~key_prev_q;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      key_s1_q     <= '0;
      key_s2_q     <= '0;
      key_stable_q <= '0;
      key_prev_q   <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        key_cnt_q[i] <= '0;
      end
      sw_s1_q      <= 1'b0;
      sw_s2_q      <= 1'b0;
      sw_stable_q  <= 1'b0;
      sw_cnt_q     <= '0;
      mode_q       <= 1'b0;
      cmd_reg_q    <= '0;
      key_reg_q    <= '0;
      cmd_pulse_q  <= '0;
      key_pulse_q  <= '0;
    end else begin
      key_s1_q     <= key_p;
      key_s2_q     <= key_s1_q;
      key_stable_q <= key_stable_d;
      key_prev_q   <= key_stable_q;
      for (int i = 0; i < N_KEYS; i++) begin
        key_cnt_q[i] <= key_cnt_d[i];
      end
      sw_s1_q      <= SW;
      sw_s2_q      <= sw_s1_q;
      sw_stable_q  <= sw_stable_d;
      sw_cnt_q     <= sw_cnt_d;
      mode_q       <= mode_d;
      cmd_reg_q    <= key_stable_q & {N_KEYS{mode_q}};
      key_reg_q    <= key_stable_q & {N_KEYS{~mode_q}};
      cmd_pulse_q  <= rise & {N_KEYS{mode_q}};
      key_pulse_q  <= rise & {N_KEYS{~mode_q}};
    end
  end

  assign CMD_Reg   = cmd_reg_q;
  assign KEY_Reg   = key_reg_q;
  assign CMD_Pulse = cmd_pulse_q;
  assign KEY_Pulse = key_pulse_q;
  assign MODE      = mode_q;

endmodule

// File: tb/tb_button_router.sv
// Scoreboard bench for button_router: a sliding-window reference model predicts every cycle's outputs.
module tb_button_router;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int CW = 3;

  typedef logic [4*N:0] obs_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sw;
  logic [N-1:0] key;
  logic [N-1:0] cmd_reg, key_reg, cmd_pulse, key_pulse;
  logic         mode;

  always #5 clk = ~clk;

  button_router #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b1), .CNT_W(CW)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .SW       (sw),
    .KEY      (key),
    .CMD_Reg  (cmd_reg),
    .KEY_Reg  (key_reg),
    .CMD_Pulse(cmd_pulse),
    .KEY_Pulse(key_pulse),
    .MODE     (mode)
  );

  obs_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   kp_cnt[N];
  int   cp_cnt[N];
  bit   saw_1001 = 1'b0;

  // Reference model: a level is accepted once the last D synchronised samples all disagree with it.
  logic [N-1:0] hist_k[$];
  logic         hist_s[$];
  logic [N-1:0] m_stable, m_prev;
  logic         m_sw_stable, m_mode;

  function automatic void model_reset();
    hist_k.delete();
    hist_s.delete();
    for (int i = 0; i < D + 2; i++) begin
      hist_k.push_back('0);
      hist_s.push_back(1'b0);
    end
    m_stable    = '0;
    m_prev      = '0;
    m_sw_stable = 1'b0;
    m_mode      = 1'b0;
  endfunction

  always @(posedge clk) begin
    obs_t         e;
    logic [N-1:0] ns;
    logic [N-1:0] rs;
    logic         nsw, nmode, all_opp;
    if (!rst_n) begin
      model_reset();
      e = '0;
    end else begin
      hist_k.push_back(~key);
      hist_s.push_back(sw);
      while (hist_k.size() > D + 2) begin
        void'(hist_k.pop_front());
        void'(hist_s.pop_front());
      end
      // Entry D+1 is this edge's raw sample; entries 0..D-1 are what the debouncers saw over the last D edges.
      ns = m_stable;
      for (int i = 0; i < N; i++) begin
        all_opp = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (hist_k[j][i] == m_stable[i]) all_opp = 1'b0;
        end
        if (all_opp) ns[i] = ~m_stable[i];
      end
      all_opp = 1'b1;
      for (int j = 0; j < D; j++) begin
        if (hist_s[j] == m_sw_stable) all_opp = 1'b0;
      end
      nsw   = all_opp ? ~m_sw_stable : m_sw_stable;
      nmode = (m_stable == '0) ? m_sw_stable : m_mode;
      rs    = m_stable & ~m_prev;
      e = {nmode,
           m_stable & {N{m_mode}}, m_stable & {N{~m_mode}},
           rs & {N{m_mode}},       rs & {N{~m_mode}}};
      m_prev      = m_stable;
      m_stable    = ns;
      m_sw_stable = nsw;
      m_mode      = nmode;
    end
    sb_q.push_back(e);
  end

  initial begin
    forever begin
      obs_t e;
      obs_t a;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {mode, cmd_reg, key_reg, cmd_pulse, key_pulse};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outputs t=%0t act={mode,cmd_reg,key_reg,cmd_pulse,key_pulse}=%b exp=%b", $time, a, e);
        end
        for (int i = 0; i < N; i++) begin
          if (key_pulse[i] === 1'b1) kp_cnt[i]++;
          if (cmd_pulse[i] === 1'b1) cp_cnt[i]++;
        end
        if (key_pulse === 4'b1001) saw_1001 = 1'b1;
      end
    end
  end

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int cmd_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += cp_cnt[i];
    return s;
  endfunction

  initial begin
    int b0, b1;
    for (int i = 0; i < N; i++) begin
      kp_cnt[i] = 0;
      cp_cnt[i] = 0;
    end
    rst_n = 1'b0;
    sw    = 1'b0;
    key   = 4'b1111;
    step(3);
    check_int("reset_outputs", int'({mode, cmd_reg, key_reg, cmd_pulse, key_pulse}), 0);
    rst_n = 1'b1;
    step(3);

    // Single press in value mode, exact latency.
    b0  = kp_cnt[0];
    key = 4'b1110;
    step(6);
    check_int("t1_key_reg_before", int'(key_reg), 0);
    step(1);
    check_int("t1_key_reg", int'(key_reg), 1);
    check_int("t1_key_pulse", int'(key_pulse), 1);
    step(1);
    check_int("t1_pulse_width", int'(key_pulse), 0);
    step(6);
    check_int("t1_pulse_count", kp_cnt[0] - b0, 1);
    check_int("t1_cmd_reg", int'(cmd_reg), 0);
    key = 4'b1111;
    step(10);
    check_int("t1_release", int'(key_reg), 0);

    // Command mode press.
    sw = 1'b1;
    step(12);
    check_int("t2_mode", int'(mode), 1);
    b0  = cp_cnt[2];
    key = 4'b1011;
    step(10);
    check_int("t2_cmd_pulse_count", cp_cnt[2] - b0, 1);
    check_int("t2_cmd_reg", int'(cmd_reg), 4);
    check_int("t2_key_reg", int'(key_reg), 0);
    key = 4'b1111;
    step(10);

    // Bounce shorter than the debounce window, then a real press.
    b1  = kp_cnt[1] + cp_cnt[1];
    key = 4'b1101; step(3);
    key = 4'b1111; step(1);
    key = 4'b1101; step(2);
    key = 4'b1111; step(10);
    check_int("t3_glitch_pulses", kp_cnt[1] + cp_cnt[1] - b1, 0);
    check_int("t3_glitch_regs", int'(cmd_reg | key_reg), 0);
    key = 4'b1101; step(5);
    key = 4'b1111; step(10);
    check_int("t3_real_pulses", kp_cnt[1] + cp_cnt[1] - b1, 1);

    // Mode change deferred while a key is held.
    sw = 1'b0;
    step(12);
    check_int("t4_mode_value", int'(mode), 0);
    key = 4'b1110;
    step(12);
    sw = 1'b1;
    step(12);
    check_int("t4_mode_held", int'(mode), 0);
    check_int("t4_key_reg_held", int'(key_reg), 1);
    b0  = cmd_total();
    key = 4'b1111;
    step(12);
    check_int("t4_mode_applied", int'(mode), 1);
    check_int("t4_no_cmd_pulse", cmd_total() - b0, 0);
    check_int("t4_cmd_reg", int'(cmd_reg), 0);

    // Simultaneous presses.
    sw = 1'b0;
    step(12);
    saw_1001 = 1'b0;
    key = 4'b0110;
    step(12);
    check_int("t5_joint_pulse", int'(saw_1001), 1);
    key = 4'b1111;
    step(10);

    // Reset in the middle of a debounce, key still held afterwards.
    b0  = kp_cnt[0];
    key = 4'b1110;
    step(5);
    rst_n = 1'b0;
    step(1);
    check_int("t6_reset_outputs", int'({mode, cmd_reg, key_reg, cmd_pulse, key_pulse}), 0);
    rst_n = 1'b1;
    step(6);
    check_int("t6_pulse_before", int'(key_pulse), 0);
    step(1);
    check_int("t6_pulse", int'(key_pulse), 1);
    step(4);
    check_int("t6_pulse_count", kp_cnt[0] - b0, 1);
    key = 4'b1111;
    step(10);

    // Randomised bouncing, mode flips and occasional resets.
    for (int it = 0; it < 400; it++) begin
      key = N'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) sw = ~sw;
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
      step($urandom_range(1, 8));
    end
    key = 4'b1111;
    step(15);
    check_int("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
